gcd_wb_sequencer: RTL and testbench

//  Wishbone-slave front end that feeds the sequential GCD engine: buffers operand pairs

---
 rtl/gcd_seq_pkg.sv | 39 +++
 rtl/gcd_sync_fifo.sv | 48 ++++
 rtl/gcd_wb_sequencer.sv | 179 +++++++++++++++++
 tb/tb_gcd_wb_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_seq_pkg.sv
// Shared definitions for the GCD Wishbone sequencer: register map, STATUS layout,
// issue-FSM states and the operand-pair payload.
package gcd_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 8;

  localparam logic [OFF_W-1:0] REG_A_STAGE = 8'h00;
  localparam logic [OFF_W-1:0] REG_B_PUSH  = 8'h04;
  localparam logic [OFF_W-1:0] REG_RESULT  = 8'h08;
  localparam logic [OFF_W-1:0] REG_STATUS  = 8'h0C;
  localparam logic [OFF_W-1:0] REG_CTRL    = 8'h10;

  localparam int unsigned ST_OP_FULL       = 0;
  localparam int unsigned ST_OP_EMPTY      = 1;
  localparam int unsigned ST_RES_FULL      = 2;
  localparam int unsigned ST_RES_EMPTY     = 3;
  localparam int unsigned ST_BUSY          = 4;
  localparam int unsigned ST_OVERFLOW      = 5;
  localparam int unsigned ST_UNDERFLOW     = 6;
  localparam int unsigned ST_RES_LOST      = 7;
  localparam int unsigned ST_RES_COUNT_LSB = 8;
  localparam int unsigned ST_RES_COUNT_W   = 8;

  localparam int unsigned CTRL_IRQ_EN    = 0;
  localparam int unsigned CTRL_CLR_STICK = 1;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_ISSUE = 2'd1,
    FSM_BUSY  = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/gcd_sync_fifo.sv
// Single-clock FIFO with extra-MSB binary pointers; a pop frees room for a push in
// the same cycle, so a full FIFO still accepts a write while it is being drained.
module gcd_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata_c,
  output logic                        full_c,
  output logic                        empty_c,
  output logic [$clog2(DEPTH):0]      count_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count_c   = wr_ptr - rd_ptr;
  assign rdata_c   = mem[rd_ptr[AW-1:0]];
  assign do_pop_c  = pop & ~empty_c;
  assign do_push_c = push & (~full_c | do_pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; empty_c guards every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gcd_wb_sequencer.sv
// Wishbone slave that queues operand pairs for the sequential GCD engine, issues
// one-cycle loads and collects results into a readable FIFO with status and IRQ.
module gcd_wb_sequencer
  import gcd_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
  parameter int unsigned OP_DEPTH  = 4,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              gcd_load_o,
  output logic [DATA_W-1:0] gcd_a_o,
  output logic [DATA_W-1:0] gcd_b_o,
  input  logic              gcd_done_i,
  input  logic [DATA_W-1:0] gcd_result_i,
  output logic              irq_o
);

  localparam int unsigned OP_CW  = $clog2(OP_DEPTH) + 1;
  localparam int unsigned RES_CW = $clog2(RES_DEPTH) + 1;

  fsm_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_stage;
  logic              irq_en;
  logic              overflow, underflow, res_lost;

  logic              valid_c, acc_c, wr_c, rd_c;
  logic [OFF_W-1:0]  off_c;
  logic              op_push_c, op_pop_c, res_push_c, res_pop_c;
  op_pair_t          op_wdata_c, op_head_c;
  logic              op_full_c, op_empty_c;
  logic [OP_CW-1:0]  op_count_unused;
  logic [DATA_W-1:0] res_head_c;
  logic              res_full_c, res_empty_c;
  logic [RES_CW-1:0] res_count_c;
  logic [DATA_W-1:0] status_c, rdata_c;
  logic              sel_unused;

  // Byte selects play no part: every register write is full-word.
  assign sel_unused = ^wbs_sel_i;

  // An access is taken once, on the edge that raises ack.
  assign valid_c = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign acc_c   = valid_c & ~wbs_ack_o;
  assign wr_c    = acc_c & wbs_we_i;
  assign rd_c    = acc_c & ~wbs_we_i;
  assign off_c   = wbs_adr_i[OFF_W-1:0];

  assign op_push_c  = wr_c & (off_c == REG_B_PUSH);
  assign op_pop_c   = (state_q == FSM_ISSUE);
  assign res_pop_c  = rd_c & (off_c == REG_RESULT);
  assign res_push_c = (state_q == FSM_BUSY) & gcd_done_i;
  assign op_wdata_c = '{a: a_stage, b: wbs_dat_i};

  gcd_sync_fifo #(.WIDTH($bits(op_pair_t)), .DEPTH(OP_DEPTH)) u_op_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (op_push_c),
    .wdata   (op_wdata_c),
    .pop     (op_pop_c),
    .rdata_c (op_head_c),
    .full_c  (op_full_c),
    .empty_c (op_empty_c),
    .count_c (op_count_unused)
  );

  gcd_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (res_push_c),
    .wdata   (gcd_result_i),
    .pop     (res_pop_c),
    .rdata_c (res_head_c),
    .full_c  (res_full_c),
    .empty_c (res_empty_c),
    .count_c (res_count_c)
  );

  // Issue FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FSM_IDLE:  if (!op_empty_c && !res_full_c) state_d = FSM_ISSUE;
      FSM_ISSUE: state_d = FSM_BUSY;
      FSM_BUSY:  if (gcd_done_i) state_d = FSM_IDLE;
      default:   state_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FSM_IDLE;
    else        state_q <= state_d;
  end

  // Engine interface: operands latched at issue and held until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcd_load_o <= 1'b0;
      gcd_a_o    <= '0;
      gcd_b_o    <= '0;
    end else begin
      gcd_load_o <= op_pop_c;
      if (op_pop_c) begin
        gcd_a_o <= op_head_c.a;
        gcd_b_o <= op_head_c.b;
      end
    end
  end

  always_comb begin
    status_c                                        = '0;
    status_c[ST_OP_FULL]                            = op_full_c;
    status_c[ST_OP_EMPTY]                           = op_empty_c;
    status_c[ST_RES_FULL]                           = res_full_c;
    status_c[ST_RES_EMPTY]                          = res_empty_c;
    status_c[ST_BUSY]                               = (state_q != FSM_IDLE);
    status_c[ST_OVERFLOW]                           = overflow;
    status_c[ST_UNDERFLOW]                          = underflow;
    status_c[ST_RES_LOST]                           = res_lost;
    status_c[ST_RES_COUNT_LSB +: ST_RES_COUNT_W]    = ST_RES_COUNT_W'(res_count_c);
  end

  always_comb begin
    rdata_c = '0;
    case (off_c)
      REG_A_STAGE: rdata_c = a_stage;
      REG_RESULT:  rdata_c = res_empty_c ? '0 : res_head_c;
      REG_STATUS:  rdata_c = status_c;
      REG_CTRL:    rdata_c = DATA_W'(irq_en);
      default:     rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc_c;
      wbs_dat_o <= rd_c ? rdata_c : '0;
    end
  end

  // CSRs; a sticky event in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_stage   <= '0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      res_lost  <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      if (wr_c && off_c == REG_A_STAGE) a_stage <= wbs_dat_i;
      if (wr_c && off_c == REG_CTRL) begin
        irq_en <= wbs_dat_i[CTRL_IRQ_EN];
        if (wbs_dat_i[CTRL_CLR_STICK]) begin
          overflow  <= 1'b0;
          underflow <= 1'b0;
          res_lost  <= 1'b0;
        end
      end
      if (op_push_c && op_full_c && !op_pop_c)    overflow  <= 1'b1;
      if (res_pop_c && res_empty_c)               underflow <= 1'b1;
      if (res_push_c && res_full_c && !res_pop_c) res_lost  <= 1'b1;
      irq_o <= irq_en & ~res_empty_c;
    end
  end

endmodule

// File: tb/tb_gcd_wb_sequencer.sv
// Randomized bench for gcd_wb_sequencer: a behavioural GCD engine plus queue-based
// reference of pushed pairs and expected results, checked over Wishbone.
module tb_gcd_wb_sequencer;

  localparam logic [31:0] BASE      = 32'h3000_0000;
  localparam logic [31:0] A_STAGE   = BASE + 32'h00;
  localparam logic [31:0] B_PUSH    = BASE + 32'h04;
  localparam logic [31:0] RESULT    = BASE + 32'h08;
  localparam logic [31:0] STATUS    = BASE + 32'h0C;
  localparam logic [31:0] CTRL      = BASE + 32'h10;
  localparam logic [31:0] UNMAPPED  = BASE + 32'h14;
  localparam int          OP_DEPTH  = 4;
  localparam logic [31:0] ST_IDLE_E = 32'h0000_000A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        gcd_load_o;
  logic [31:0] gcd_a_o, gcd_b_o;
  logic        gcd_done_i;
  logic [31:0] gcd_result_i;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_pairs[$];
  logic [31:0] exp_res[$];
  logic        stall;

  gcd_wb_sequencer #(.BASE_ADR(BASE), .OP_DEPTH(OP_DEPTH), .RES_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .gcd_load_o   (gcd_load_o),
    .gcd_a_o      (gcd_a_o),
    .gcd_b_o      (gcd_b_o),
    .gcd_done_i   (gcd_done_i),
    .gcd_result_i (gcd_result_i),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural engine: latches operands on load, answers after 1-4 cycles unless stalled.
  initial begin
    logic        eng_busy;
    int          cnt;
    logic [31:0] pend;
    logic [63:0] p;
    eng_busy     = 1'b0;
    cnt          = 0;
    pend         = '0;
    gcd_done_i   = 1'b0;
    gcd_result_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        gcd_done_i = 1'b0;
        eng_busy   = 1'b0;
      end else begin
        gcd_done_i = 1'b0;
        if (gcd_load_o) begin
          check("load_while_engine_busy", 32'(eng_busy), 32'd0);
          if (exp_pairs.size() == 0) begin
            check("load_unexpected", 32'd1, 32'd0);
          end else begin
            p = exp_pairs.pop_front();
            check("load_a", gcd_a_o, p[63:32]);
            check("load_b", gcd_b_o, p[31:0]);
          end
          pend     = ref_gcd(gcd_a_o, gcd_b_o);
          cnt      = $urandom_range(0, 3);
          eng_busy = 1'b1;
        end else if (eng_busy && !stall) begin
          if (cnt == 0) begin
            gcd_done_i   = 1'b1;
            gcd_result_i = pend;
            eng_busy     = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    logic got;
    @(posedge clk);
    #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = 4'hF;
    wbs_adr_i = adr;
    wbs_dat_i = wdata;
    rdata     = '0;
    got       = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge clk);
      #1;
      if (wbs_ack_o) begin
        got   = 1'b1;
        rdata = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdata);
    logic [31:0] dummy;
    wb_access(1'b1, adr, wdata, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdata);
    wb_access(1'b0, adr, '0, rdata);
  endtask

  // A pair is kept only while fewer than OP_DEPTH pairs wait behind the engine.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    if (exp_pairs.size() < OP_DEPTH) begin
      exp_pairs.push_back({a, b});
      exp_res.push_back(ref_gcd(a, b));
    end
    wb_write(A_STAGE, a);
    wb_write(B_PUSH, b);
  endtask

  task automatic wait_status(input int bit_idx, input logic val, input string tag);
    logic [31:0] s;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      wb_read(STATUS, s);
      if (s[bit_idx] == val) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic drain(input string tag);
    logic [31:0] d;
    while (exp_res.size() > 0) begin
      wait_status(3, 1'b0, "res_ready_timeout");
      wb_read(RESULT, d);
      check(tag, d, exp_res.pop_front());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, g, a, b;
    rst_n     = 1'b0;
    stall     = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_load", 32'(gcd_load_o), 32'd0);
    check("rst_a", gcd_a_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst_n = 1'b1;
    wb_read(STATUS, d);  check("rst_status", d, ST_IDLE_E);
    wb_read(A_STAGE, d); check("rst_a_stage", d, 32'd0);
    wb_read(CTRL, d);    check("rst_ctrl", d, 32'd0);

    // Single pair.
    push_pair(32'd48, 32'd18);
    wb_read(A_STAGE, d); check("a_stage_rb", d, 32'd48);
    drain("single_result");
    wb_read(STATUS, d);  check("single_status", d, ST_IDLE_E);

    // Ordered batch including a zero operand.
    push_pair(32'd48, 32'd18);
    push_pair(32'd100, 32'd75);
    push_pair(32'd17, 32'd5);
    push_pair(32'd0, 32'd9);
    drain("batch_result");

    // Underflow: empty read returns 0 and leaves the pointers alone.
    wb_read(RESULT, d); check("underflow_data", d, 32'd0);
    wb_read(STATUS, d); check("underflow_status", d, 32'h0000_004A);
    push_pair(32'd35, 32'd14);
    drain("after_underflow");
    wb_write(CTRL, 32'h2);
    wb_read(STATUS, d); check("underflow_cleared", d, ST_IDLE_E);

    // Unmapped offset and write-only register read back as zero.
    wb_write(UNMAPPED, 32'hFFFF_FFFF);
    wb_read(UNMAPPED, d); check("unmapped_read", d, 32'd0);
    wb_read(B_PUSH, d);   check("b_push_read", d, 32'd0);
    wb_read(STATUS, d);   check("unmapped_no_effect", d, ST_IDLE_E);

    // Overflow: one pair sits in the stalled engine, so the sixth push is the one dropped.
    stall = 1'b1;
    push_pair(32'd30, 32'd12);
    wait_status(4, 1'b1, "busy_timeout");
    for (int i = 2; i <= 5; i++) push_pair(32'(i * 21), 32'(i * 6));
    wb_read(STATUS, d);
    check("ovf_full_before", 32'(d[0]), 32'd1);
    check("ovf_not_yet", 32'(d[5]), 32'd0);
    push_pair(32'd99, 32'd33);
    wb_read(STATUS, d);
    check("ovf_set", 32'(d[5]), 32'd1);
    check("ovf_full_after", 32'(d[0]), 32'd1);
    wb_write(CTRL, 32'h2);
    wb_read(STATUS, d);
    check("ovf_cleared", 32'(d[5]), 32'd0);
    stall = 1'b0;
    drain("ovf_result");

    // Interrupt follows the result FIFO with a one-cycle lag.
    wb_write(CTRL, 32'h1);
    push_pair(32'd12, 32'd8);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(posedge clk);
        #1;
        if (irq_o) seen = 1'b1;
      end
      check("irq_rise", 32'(seen), 32'd1);
    end
    wb_read(RESULT, d); check("irq_result", d, exp_res.pop_front());
    repeat (2) @(posedge clk);
    #1;
    check("irq_fall", 32'(irq_o), 32'd0);
    wb_write(CTRL, 32'h0);

    // Random batches sized to stay within the operand FIFO.
    for (int n = 0; n < 8; n++) begin
      int cnt;
      cnt = $urandom_range(1, OP_DEPTH);
      for (int k = 0; k < cnt; k++) begin
        g = 32'($urandom_range(1, 60));
        a = g * 32'($urandom_range(0, 40));
        b = g * 32'($urandom_range(0, 40));
        push_pair(a, b);
      end
      drain("rand_result");
    end
    wb_read(STATUS, d); check("rand_status", d, ST_IDLE_E);

    // Reset while the engine is busy discards everything.
    stall = 1'b1;
    push_pair(32'd20, 32'd15);
    wait_status(4, 1'b1, "busy_timeout_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_pairs.delete();
    exp_res.delete();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_load", 32'(gcd_load_o), 32'd0);
    check("midrst_a", gcd_a_o, 32'd0);
    check("midrst_b", gcd_b_o, 32'd0);
    check("midrst_ack", 32'(wbs_ack_o), 32'd0);
    check("midrst_dat", wbs_dat_o, 32'd0);
    check("midrst_irq", 32'(irq_o), 32'd0);
    stall = 1'b0;
    rst_n = 1'b1;
    wb_read(STATUS, d); check("midrst_status", d, ST_IDLE_E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
